// File: rtl/mel_pkg.sv
// Shared MEL front-end constants and the power-spectrum FSM state type.
package mel_pkg;
    localparam int FFT_ADDR_WIDTH = 8;
    localparam int FFT_N          = 1 << FFT_ADDR_WIDTH;
    localparam int FFT_HALF       = FFT_N / 2;
    localparam int SAMPLE_WIDTH   = 16;
    localparam int PWR_WIDTH      = 2 * SAMPLE_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SKIP = 2'd2
    } pwr_state_t;
endpackage

// File: rtl/cplx_sq_mag.sv
// Two-stage |x|^2 pipeline: stage 1 squares re and im, stage 2 adds them.
// Every register, valid and tag included, holds while en_i is low.
module cplx_sq_mag #(
    parameter int W     = 16,
    parameter int TAG_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 vld_i,
    input  logic signed [W-1:0]  re_i,
    input  logic signed [W-1:0]  im_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 vld_o,
    output logic [2*W-1:0]       pwr_o,
    output logic [TAG_W-1:0]     tag_o
);
    logic signed [2*W-1:0] re_sq_d, im_sq_d;
    logic signed [2*W-1:0] re_sq_q, im_sq_q;
    logic                  s1_vld_q;
    logic [TAG_W-1:0]      s1_tag_q;
    logic [2*W-1:0]        pwr_d, pwr_q;
    logic                  s2_vld_q;
    logic [TAG_W-1:0]      s2_tag_q;

    assign re_sq_d = (2*W)'(re_i) * (2*W)'(re_i);
    assign im_sq_d = (2*W)'(im_i) * (2*W)'(im_i);
    // Each square is at most 2^(2W-2), so the unsigned sum tops out at 2^(2W-1).
    assign pwr_d   = $unsigned(re_sq_q) + $unsigned(im_sq_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_sq_q  <= '0;
            im_sq_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_tag_q <= '0;
            pwr_q    <= '0;
            s2_vld_q <= 1'b0;
            s2_tag_q <= '0;
        end else if (en_i) begin
            re_sq_q  <= re_sq_d;
            im_sq_q  <= im_sq_d;
            s1_vld_q <= vld_i;
            s1_tag_q <= tag_i;
            pwr_q    <= pwr_d;
            s2_vld_q <= s1_vld_q;
            s2_tag_q <= s1_tag_q;
        end
    end

    assign vld_o = s2_vld_q;
    assign pwr_o = pwr_q;
    assign tag_o = s2_tag_q;
endmodule

// File: rtl/power_spectrum.sv
// Drains each completed FFT frame in bin order, emitting |X[k]|^2 for k = 0..N/2 and
// reading past the mirrored bins so the buffer's read counter stays frame-aligned.
module power_spectrum #(
    parameter int SAMPLE_WIDTH = mel_pkg::SAMPLE_WIDTH,
    parameter int ADDR_WIDTH   = mel_pkg::FFT_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_rdy,
    input  logic [2*SAMPLE_WIDTH-1:0] bin_in,
    output logic                      rd_en,
    output logic [2*SAMPLE_WIDTH-1:0] pwr_out,
    output logic                      pwr_valid,
    input  logic                      pwr_ready,
    output logic [ADDR_WIDTH-1:0]     bin_idx,
    output logic                      frame_last,
    output logic                      overrun
);
    import mel_pkg::*;

    localparam int                    N        = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] HALF_IDX = ADDR_WIDTH'(N / 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
    localparam int                    TAG_W    = ADDR_WIDTH + 1;

    pwr_state_t              state_d, state_q;
    logic [ADDR_WIDTH-1:0]   rd_cnt_d, rd_cnt_q;
    logic                    pending_d, pending_q;
    logic                    overrun_d, overrun_q;
    logic                    adv;
    logic                    feed;
    logic signed [SAMPLE_WIDTH-1:0] re_in, im_in;
    logic [TAG_W-1:0]        tag_in, tag_out;

    assign adv = !(pwr_valid && !pwr_ready);

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        rd_en     = 1'b0;
        feed      = 1'b0;

        if (frame_rdy && state_q != IDLE) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_rdy || pending_q) begin
                    state_d   = READ;
                    rd_cnt_d  = '0;
                    pending_d = 1'b0;
                end
            end
            READ: begin
                rd_en = adv;
                feed  = adv;
                if (adv) begin
                    rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
                    if (rd_cnt_q == HALF_IDX) state_d = SKIP;
                end
            end
            SKIP: begin
                // Mirrored bins are read unconditionally so the frame always spans N reads.
                rd_en    = 1'b1;
                rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
                if (rd_cnt_q == LAST_IDX) begin
                    if (pending_q || frame_rdy) begin
                        state_d   = READ;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign re_in  = bin_in[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
    assign im_in  = bin_in[SAMPLE_WIDTH-1:0];
    assign tag_in = {rd_cnt_q == HALF_IDX, rd_cnt_q};

    cplx_sq_mag #(
        .W     (SAMPLE_WIDTH),
        .TAG_W (TAG_W)
    ) u_sq_mag (
        .clk   (clk),
        .rst   (rst),
        .en_i  (adv),
        .vld_i (feed),
        .re_i  (re_in),
        .im_i  (im_in),
        .tag_i (tag_in),
        .vld_o (pwr_valid),
        .pwr_o (pwr_out),
        .tag_o (tag_out)
    );

    assign bin_idx    = tag_out[ADDR_WIDTH-1:0];
    assign frame_last = tag_out[ADDR_WIDTH];
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_power_spectrum.sv
// Bench for power_spectrum at N = 8: emulates the reorder buffer read side and
// predicts the bin stream, overrun flag and read strobe from frame-level rules.
module tb_power_spectrum;
    localparam int W    = 16;
    localparam int AW   = 3;
    localparam int N    = 8;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_rdy = 1'b0;
    logic          pwr_ready = 1'b1;
    logic [2*W-1:0] bin_in;
    logic          rd_en;
    logic [2*W-1:0] pwr_out;
    logic          pwr_valid;
    logic [AW-1:0] bin_idx;
    logic          frame_last;
    logic          overrun;

    power_spectrum #(.SAMPLE_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_rdy  (frame_rdy),
        .bin_in     (bin_in),
        .rd_en      (rd_en),
        .pwr_out    (pwr_out),
        .pwr_valid  (pwr_valid),
        .pwr_ready  (pwr_ready),
        .bin_idx    (bin_idx),
        .frame_last (frame_last),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pwr;
        int          idx;
        logic        last;
    } bin_t;

    bin_t exp_q[$];
    bin_t got_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Buffer emulation and frame bookkeeping.
    int   rd_ptr = 0, frm_no = 0, acc_cnt = 0, outstanding = 0, rd_total = 0;
    logic exp_overrun = 1'b0;
    logic wrap_ev, acc_ev;

    logic [31:0] t1_pwr [5] = '{32'd0, 32'd2, 32'd8, 32'd18, 32'd32};

    function automatic int frame_re(int f, int k);
        if (f == 0) return k;
        if (f == 1) return (k == 0) ? -32768 : (k == 1) ? 32767 : -k * 1000;
        return (f * 37 + k * 101) - 300;
    endfunction

    function automatic int frame_im(int f, int k);
        if (f == 0) return -k;
        if (f == 1) return (k == 0) ? -32768 : (k == 1) ? 0 : k * 3 + 1;
        return 150 - f * 13 - k * 7;
    endfunction

    function automatic logic [31:0] frame_bin(int f, int k);
        int re, im;
        re = frame_re(f, k);
        im = frame_im(f, k);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic logic [31:0] exp_pwr(int f, int k);
        longint re, im, p;
        re = longint'(frame_re(f, k));
        im = longint'(frame_im(f, k));
        p  = re * re + im * im;
        return p[31:0];
    endfunction

    assign bin_in  = frame_bin(frm_no, rd_ptr);
    assign wrap_ev = rd_en && (rd_ptr == N - 1);
    assign acc_ev  = frame_rdy && (outstanding < 2);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A frame is accepted while at most one is in flight; the accepted ones drain in order.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            rd_ptr      <= 0;
            outstanding <= 0;
            frm_no      <= acc_cnt;
            exp_overrun <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_total <= rd_total + 1;
                rd_ptr   <= (rd_ptr == N - 1) ? 0 : rd_ptr + 1;
                if (wrap_ev) frm_no <= frm_no + 1;
            end
            if (acc_ev) begin
                for (int k = 0; k <= HALF; k++)
                    exp_q.push_back('{pwr: exp_pwr(acc_cnt, k), idx: k, last: (k == HALF)});
                acc_cnt <= acc_cnt + 1;
            end else if (frame_rdy) begin
                exp_overrun <= 1'b1;
            end
            outstanding <= outstanding + (acc_ev ? 1 : 0) - (wrap_ev ? 1 : 0);
        end
    end

    function automatic logic exp_rd_en();
        if (outstanding == 0) return 1'b0;
        if (rd_ptr <= HALF)   return !(pwr_valid && !pwr_ready);
        return 1'b1;
    endfunction

    logic          prev_hold = 1'b0;
    logic [31:0]   prev_pwr = '0;
    logic [AW-1:0] prev_idx = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            check("overrun", overrun, exp_overrun);
            check("rd_en", rd_en, exp_rd_en());
            if (prev_hold) begin
                check("hold_vld", pwr_valid, 1'b1);
                check("hold_pwr", pwr_out, prev_pwr);
                check("hold_idx", bin_idx, prev_idx);
                check("hold_last", frame_last, prev_last);
            end
            if (pwr_valid) begin
                check("bin_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    check("pwr", pwr_out, exp_q[0].pwr);
                    check("idx", bin_idx, exp_q[0].idx);
                    check("last", frame_last, exp_q[0].last);
                    if (pwr_ready) begin
                        got_log.push_back('{pwr: pwr_out, idx: int'(bin_idx), last: frame_last});
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_hold <= pwr_valid && !pwr_ready;
            prev_pwr  <= pwr_out;
            prev_idx  <= bin_idx;
            prev_last <= frame_last;
        end
    end

    task automatic pulse_frame();
        @(posedge clk); #1 frame_rdy = 1'b1;
        @(posedge clk); #1 frame_rdy = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((outstanding != 0 || exp_q.size() != 0 || pwr_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, n < 300, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"}, rd_en, 1'b0);
        check({tag, "_pwr_valid"}, pwr_valid, 1'b0);
        check({tag, "_pwr_out"}, pwr_out, 32'd0);
        check({tag, "_bin_idx"}, bin_idx, 3'd0);
        check({tag, "_frame_last"}, frame_last, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        int rd0, n, sz;
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        rst = 1'b0;

        // Frame 0: re = k, im = -k; timing of first read and first output.
        pulse_frame();
        @(negedge clk); check("t1_first_rd", rd_en, 1'b1); check("t1_vld_c1", pwr_valid, 1'b0);
        @(negedge clk); check("t1_vld_c2", pwr_valid, 1'b0);
        @(negedge clk); check("t1_vld_c3", pwr_valid, 1'b1); check("t1_idx0", bin_idx, 3'd0);
        wait_drain("t1");
        check("t1_rd_total", rd_total, 8);
        check("t1_log_size", got_log.size(), 5);
        for (int k = 0; k < 5 && k < got_log.size(); k++) begin
            check($sformatf("t1_pwr%0d", k), got_log[k].pwr, t1_pwr[k]);
            check($sformatf("t1_idx%0d", k), got_log[k].idx, k);
            check($sformatf("t1_last%0d", k), got_log[k].last, k == 4);
        end

        // Frame 1: extreme magnitudes.
        pulse_frame();
        wait_drain("t2");
        check("t2_log_size", got_log.size(), 10);
        if (got_log.size() >= 7) begin
            check("t2_min_min", got_log[5].pwr, 32'h8000_0000);
            check("t2_max_zero", got_log[6].pwr, 32'h3FFF_0001);
        end

        // Frame 2: three-cycle backpressure mid-READ.
        rd0 = rd_total;
        pulse_frame();
        n = 0;
        while (!(pwr_valid && bin_idx == 3'd1) && n < 50) begin @(negedge clk); n++; end
        check("t3_find_bin1", n < 50, 1'b1);
        @(posedge clk); #1 pwr_ready = 1'b0;
        @(negedge clk);
        check("t3_rd_drop", rd_en, 1'b0);
        check("t3_stall_vld", pwr_valid, 1'b1);
        check("t3_stall_idx", bin_idx, 3'd2);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 pwr_ready = 1'b1;
        wait_drain("t3");
        check("t3_rd_count", rd_total - rd0, 8);
        check("t3_log_size", got_log.size(), 15);

        // Frames 3..6: back-to-back every N cycles.
        rd0 = rd_total;
        for (int f = 0; f < 4; f++) begin
            @(posedge clk); #1 frame_rdy = 1'b1;
            @(posedge clk); #1 frame_rdy = 1'b0;
            repeat (6) @(posedge clk);
        end
        wait_drain("t4");
        check("t4_overrun", overrun, 1'b0);
        check("t4_rd_count", rd_total - rd0, 32);
        check("t4_log_size", got_log.size(), 35);

        // Three frame_rdy pulses inside one frame: third is dropped.
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1 frame_rdy = 1'b1;
            @(posedge clk); #1 frame_rdy = 1'b0;
        end
        @(negedge clk); check("t5_overrun", overrun, 1'b1);
        wait_drain("t5");
        check("t5_overrun_sticky", overrun, 1'b1);
        check("t5_log_size", got_log.size(), 45);

        // Reset during SKIP, then a clean frame.
        pulse_frame();
        n = 0;
        do begin @(posedge clk); #1; n++; end while (rd_ptr != 6 && n < 50);
        check("t6_reach_skip", n < 50, 1'b1);
        check("t6_pre_overrun", overrun, 1'b1);
        rst = 1'b1;
        #1 check_zero_outputs("t6_rst");
        @(posedge clk); #1 rst = 1'b0;
        sz = got_log.size();
        pulse_frame();
        wait_drain("t6");
        check("t6_log_size", got_log.size(), sz + 5);
        if (got_log.size() > sz) check("t6_first_idx", got_log[sz].idx, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/power_spectrum.md
# power_spectrum

Downstream consumer of the bit-reverse reorder ping-pong buffer in the MEL front end. Each time the buffer signals a completed frame, this block drains that frame in natural bin order, computes the power |X[k]|² = re² + im² for the non-redundant bins k = 0..N/2 through a 2-stage pipeline, and discards the mirrored bins N/2+1..N-1. The result is a valid/ready bin stream to the mel filterbank.

## Interface
- SAMPLE_WIDTH, 16: signed width of each of re and im.
- ADDR_WIDTH, 8: log2 of FFT size N; must equal the reorder buffer's ADDR_WIDTH.
- clk  in  1  rising-edge clock; the only clock in the block.
- rst  in  1  reset, asynchronous and active-high.
- frame_rdy  in  1  one-cycle pulse; connected to the buffer's buffer_full.
- bin_in  in  2*SAMPLE_WIDTH  {re, im}, re in the MSBs; buffer data_out, combinational from its read address.
- rd_en  out  1  read strobe to the buffer; bin_in is sampled in the same cycle.
- pwr_out  out  2*SAMPLE_WIDTH  unsigned power, full precision.
- pwr_valid  out  1  pwr_out, bin_idx and frame_last are valid.
- pwr_ready  in  1  consumer accepts when pwr_valid && pwr_ready.
- bin_idx  out  ADDR_WIDTH  bin number of pwr_out, 0..N/2.
- frame_last  out  1  high with bin N/2.
- overrun  out  1  sticky error flag; cleared only by rst.

## Operation
- FSM states: IDLE, READ, SKIP. Reset state is IDLE.
- IDLE: on frame_rdy, or when pending is set, go to READ with rd_cnt = 0, and clear pending.
- READ: rd_en = adv. Each rd_en cycle feeds bin rd_cnt into the pipeline and increments rd_cnt. After the read with rd_cnt = N/2, go to SKIP.
- SKIP: rd_en = 1 every cycle, independent of pwr_ready. Nothing enters the pipeline. After the read with rd_cnt = N-1 (the buffer read counter wraps to 0), go to READ if pending, else IDLE.
- Every frame issues exactly N rd_en pulses, keeping the buffer read counter aligned to frame boundaries.
- frame_rdy while not IDLE sets pending. frame_rdy while pending is already set sets overrun; that frame is dropped and the FSM continues normally.
- Arithmetic:
  - Stage 1 registers re², im² as signed products of width 2*SAMPLE_WIDTH.
  - Stage 2 registers their sum as unsigned 2*SAMPLE_WIDTH. This cannot overflow: the maximum is 2·2^(2W-2) = 2^(2W-1).
- Pipeline carries bin_idx and frame_last alongside the data.
- adv = !(pwr_valid && !pwr_ready). All pipeline registers hold when adv = 0.

## Timing
- Reset values: rd_en = 0, pwr_out = 0, pwr_valid = 0, bin_idx = 0, frame_last = 0, overrun = 0, pending = 0, FSM = IDLE, pipeline valids = 0.
- frame_rdy at cycle t gives first rd_en at t+1 when idle.
- Latency: data sampled with rd_en at cycle c appears with pwr_valid at c+2 when adv stays high.
- Full-rate throughput: with pwr_ready held high, READ lasts N/2+1 cycles and SKIP N/2-1 cycles, so a frame drains in N cycles. This exactly matches the buffer's bank-swap period.
- Backpressure stalls READ only. The consumer must not stall more than N/2-1 cycles per frame in aggregate, or the writer swaps banks mid-read. The block does not detect this condition.
- rst mid-frame: everything returns to reset values immediately. The buffer must be reset in the same cycle to realign its counters.
- frame_rdy in the last SKIP cycle goes directly to READ with no idle cycle.

## Structure
- Shared package mel_pkg holds:
  - constants FFT_ADDR_WIDTH, FFT_N, FFT_HALF = FFT_N/2, SAMPLE_WIDTH, PWR_WIDTH = 2*SAMPLE_WIDTH;
  - FSM state typedef pwr_state_t.
- Sub-module cplx_sq_mag: the 2-stage squaring/add pipeline with enable and a valid/tag side-band.
- The FSM, counters and handshake live in power_spectrum.

## Test plan
- N = 8, frame of bins k → (re = k, im = -k), pwr_ready = 1, frame_rdy pulse:
  - 8 rd_en pulses;
  - outputs 0, 2, 8, 18, 32 with bin_idx 0..4 and frame_last on bin_idx 4;
  - first pwr_valid 2 cycles after first rd_en.
- re = im = -2^(W-1) → pwr_out = 2^(2W-1), no wrap. re = 2^(W-1)-1, im = 0 → (2^(W-1)-1)².
- pwr_ready low for 3 cycles mid-READ:
  - rd_en drops;
  - pwr_out/bin_idx held stable;
  - no bin lost or duplicated;
  - SKIP reads still total N-N/2-1.
- Back-to-back frames:
  - frame_rdy every N cycles with pwr_ready = 1 → continuous output, overrun stays 0;
  - three frame_rdy pulses within one frame → overrun = 1 and stays 1.
- rst asserted during SKIP → all outputs 0 the same cycle; the next frame_rdy yields a clean frame starting at bin_idx 0.
